// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: two-master AXI4 read arbiter onto one shared slave, one outstanding burst at a time
module axi4_rd_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [63:0] M_ARADDR,
  input  logic [15:0] M_ARLEN,
  input  logic [5:0]  M_ARSIZE,
  input  logic [3:0]  M_ARBURST,
  input  logic [1:0]  M_ARVALID,
  output logic [1:0]  M_ARREADY,
  output logic [31:0] M_RDATA,
  output logic [1:0]  M_RRESP,
  output logic        M_RLAST,
  output logic [1:0]  M_RVALID,
  input  logic [1:0]  M_RREADY,
  output logic        S_AXI_ARID,
  output logic [31:0] S_AXI_ARADDR,
  output logic [7:0]  S_AXI_ARLEN,
  output logic [2:0]  S_AXI_ARSIZE,
  output logic [1:0]  S_AXI_ARBURST,
  output logic        S_AXI_ARVALID,
  output logic        S_AXI_RREADY,
  input  logic        S_AXI_ARREADY,
  input  logic        S_AXI_RID,
  input  logic [31:0] S_AXI_RDATA,
  input  logic [1:0]  S_AXI_RRESP,
  input  logic        S_AXI_RLAST,
  input  logic        S_AXI_RVALID,
  output logic        ERR_LEN
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t      state_q, state_d;
  logic        grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, beat_q, beat_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        pick, in_addr, in_data, beat, unused_rid;
  // Winner of a contest plus phase and beat qualifiers; read ID plays no part in routing
  always_comb begin
    pick = &M_ARVALID ? (RR_EN ? ~last_q : 1'b0) : M_ARVALID[1];
    in_addr = state_q == ADDR;
    in_data = state_q == DATA;
    beat = in_data & S_AXI_RVALID & S_AXI_RREADY;
    unused_rid = S_AXI_RID;
  end
  // Next-state: grant and capture in IDLE, wait for address handshake, count beats and check length
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    err_d = err_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    beat_d = beat_q;
    case (state_q)
      IDLE: if (|M_ARVALID) begin
        state_d = ADDR;
        grant_d = pick;
        addr_d = M_ARADDR[{pick, 5'd0} +: 32];
        len_d = M_ARLEN[{pick, 3'd0} +: 8];
        size_d = pick ? M_ARSIZE[5:3] : M_ARSIZE[2:0];
        burst_d = pick ? M_ARBURST[3:2] : M_ARBURST[1:0];
      end
      ADDR: if (S_AXI_ARREADY) begin
        state_d = DATA;
        beat_d = '0;
      end
      DATA: if (beat) begin
        beat_d = beat_q + 8'd1;
        err_d = err_q | (S_AXI_RLAST ? beat_q != len_q : beat_q == len_q);
        if (S_AXI_RLAST) begin
          state_d = IDLE;
          last_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State register; reset leaves M1 as last granted so M0 wins the first contest
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      err_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      err_q <= err_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      beat_q <= beat_d;
    end
  end
  assign M_ARREADY = {2{in_addr & S_AXI_ARREADY}} & {grant_q, ~grant_q};
  assign M_RVALID = {2{in_data & S_AXI_RVALID}} & {grant_q, ~grant_q};
  assign S_AXI_RREADY = in_data & M_RREADY[grant_q];
  assign M_RDATA = S_AXI_RDATA;
  assign M_RRESP = S_AXI_RRESP;
  assign M_RLAST = S_AXI_RLAST;
  assign S_AXI_ARVALID = in_addr;
  assign S_AXI_ARID = grant_q;
  assign S_AXI_ARADDR = addr_q;
  assign S_AXI_ARLEN = len_q;
  assign S_AXI_ARSIZE = size_q;
  assign S_AXI_ARBURST = burst_q;
  assign ERR_LEN = err_q;
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb_axi4_rd_arbiter: scoreboard bench for the two-master read arbiter (round-robin and fixed-priority builds)
module tb_axi4_rd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, sel, tog;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [1:0]  m_arvalid, m_rready;
  logic        s_arready, s_rid, s_rvalid, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [1:0]  o_arready [2], o_rresp [2], o_rvalid [2], o_arburst [2];
  logic [31:0] o_rdata [2], o_araddr [2];
  logic        o_rlast [2], o_arid [2], o_arvalid [2], o_rready [2], o_err [2];
  logic [7:0]  o_arlen [2];
  logic [2:0]  o_arsize [2];
  logic [1:0]  m_arready, m_rresp, m_rvalid, s_arburst;
  logic [31:0] m_rdata, s_araddr;
  logic        m_rlast, s_arid, s_arvalid, s_rready, err;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  int checks = 0, errors = 0, beats_seen = 0, ar_delay = 0, rlast_at = 0;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    axi4_rd_arbiter #(.RR_EN(i == 0)) dut (
      .ACLK(clk), .ARESET(rst),
      .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize), .M_ARBURST(m_arburst),
      .M_ARVALID(m_arvalid), .M_ARREADY(o_arready[i]),
      .M_RDATA(o_rdata[i]), .M_RRESP(o_rresp[i]), .M_RLAST(o_rlast[i]),
      .M_RVALID(o_rvalid[i]), .M_RREADY(m_rready),
      .S_AXI_ARID(o_arid[i]), .S_AXI_ARADDR(o_araddr[i]), .S_AXI_ARLEN(o_arlen[i]),
      .S_AXI_ARSIZE(o_arsize[i]), .S_AXI_ARBURST(o_arburst[i]), .S_AXI_ARVALID(o_arvalid[i]),
      .S_AXI_RREADY(o_rready[i]), .S_AXI_ARREADY(s_arready), .S_AXI_RID(s_rid),
      .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RLAST(s_rlast),
      .S_AXI_RVALID(s_rvalid), .ERR_LEN(o_err[i])
    );
  end

  // sel=0 observes the round-robin build, sel=1 the fixed-priority build; the slave serves the selected one
  always_comb begin
    m_arready = o_arready[sel];
    m_rdata = o_rdata[sel];
    m_rresp = o_rresp[sel];
    m_rlast = o_rlast[sel];
    m_rvalid = o_rvalid[sel];
    s_arid = o_arid[sel];
    s_araddr = o_araddr[sel];
    s_arlen = o_arlen[sel];
    s_arsize = o_arsize[sel];
    s_arburst = o_arburst[sel];
    s_arvalid = o_arvalid[sel];
    s_rready = o_rready[sel];
    err = o_err[sel];
  end

  // Slave model: ARREADY after ar_delay cycles, then beats addr+i, RLAST on beat rlast_at (or ARLEN+1)
  logic        ss;
  int          dcnt;
  logic [31:0] sa;
  logic [8:0]  sn, bi;
  always @(posedge clk) begin
    if (rst) begin
      ss <= 1'b0; s_arready <= 1'b0; dcnt <= 0; sa <= '0; sn <= '0; bi <= '0;
    end else if (!ss) begin
      if (s_arvalid && s_arready) begin
        s_arready <= 1'b0; dcnt <= 0; sa <= s_araddr; bi <= '0; ss <= 1'b1;
        sn <= rlast_at != 0 ? 9'(rlast_at) : 9'(s_arlen) + 9'd1;
      end else if (s_arvalid) begin
        if (dcnt == ar_delay) s_arready <= 1'b1;
        else dcnt <= dcnt + 1;
      end
    end else if (s_rvalid && s_rready) begin
      bi <= bi + 9'd1;
      if (bi == sn - 9'd1) ss <= 1'b0;
    end
  end
  assign s_rvalid = ss;
  assign s_rdata = sa + 32'(bi);
  assign s_rresp = bi[1:0];
  assign s_rlast = bi == sn - 9'd1;
  assign s_rid = 1'b1;

  typedef struct {logic id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} ar_t;
  typedef struct {logic [1:0] vld; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
  typedef struct {logic [31:0] addr; logic [7:0] len;} rq_t;
  ar_t exp_ar[$];
  r_t  exp_r[$];
  rq_t rq0[$], rq1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: compares address fields while ARVALID is up, routing and data on every read cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (s_arvalid) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          chk("ar_fields", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
              {exp_ar[0].id, exp_ar[0].addr, exp_ar[0].len, exp_ar[0].size, exp_ar[0].burst});
          chk("m_arready", m_arready, s_arready ? (exp_ar[0].id ? 2'b10 : 2'b01) : 2'b00);
          if (s_arready) void'(exp_ar.pop_front());
        end
      end else chk("m_arready_idle", m_arready, 0);
      if (s_rvalid) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          chk("r_route", {m_rvalid, s_rready}, {exp_r[0].vld, m_rready[exp_r[0].vld[1]]});
          if (s_rready) begin
            chk("r_beat", {m_rdata, m_rresp, m_rlast}, {exp_r[0].data, exp_r[0].resp, exp_r[0].last});
            void'(exp_r.pop_front());
            beats_seen++;
          end
        end
      end else chk("m_rvalid_idle", m_rvalid, 0);
    end
  end

  task automatic req(input int m, input logic [31:0] a, input logic [7:0] l);
    if (m == 1) rq1.push_back('{a, l});
    else rq0.push_back('{a, l});
  endtask

  task automatic expect_txn(input int m, input logic [31:0] a, input logic [7:0] l, input int n);
    exp_ar.push_back('{m == 1, a, l, m == 1 ? 3'd1 : 3'd2, m == 1 ? 2'b10 : 2'b01});
    for (int i = 0; i < n; i++)
      exp_r.push_back('{m == 1 ? 2'b10 : 2'b01, a + 32'(i), i[1:0], i == n - 1});
  endtask

  task automatic load(input int m, input rq_t r);
    if (m == 1) begin
      m_araddr[63:32] = r.addr; m_arlen[15:8] = r.len; m_arsize[5:3] = 3'd1; m_arburst[3:2] = 2'b10;
      m_arvalid[1] = 1'b1;
    end else begin
      m_araddr[31:0] = r.addr; m_arlen[7:0] = r.len; m_arsize[2:0] = 3'd2; m_arburst[1:0] = 2'b01;
      m_arvalid[0] = 1'b0 | 1'b1;
    end
  endtask

  task automatic step();
    logic [1:0] hs;
    @(negedge clk);
    hs = m_arvalid & m_arready;
    @(posedge clk);
    #1;
    m_arvalid = m_arvalid & ~hs;
    if (tog) m_rready[1] = ~m_rready[1];
    if (!m_arvalid[0] && rq0.size() != 0) load(0, rq0.pop_front());
    if (!m_arvalid[1] && rq1.size() != 0) load(1, rq1.pop_front());
  endtask

  task automatic run(input int budget);
    int k = 0;
    while ((exp_r.size() != 0 || exp_ar.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || m_arvalid != 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk("run_timeout", 1, 0);
  endtask

  task automatic run_beats(input int target);
    int k = 0;
    while (beats_seen < target && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) chk("beat_timeout", 1, 0);
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b1; sel = s; tog = 1'b0; m_rready = 2'b11; m_arvalid = 2'b00;
    ar_delay = 0; rlast_at = 0;
    exp_ar.delete(); exp_r.delete(); rq0.delete(); rq1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_slave", {s_arvalid, s_rready, s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, 0);
    chk("rst_master", {m_arready, m_rvalid}, 0);
    chk("rst_err", err, 0);
  endtask

  initial begin
    int s;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    do_reset(1'b0);
    chk_reset_outs();
    // Round-robin: simultaneous requests go M0 then M1, then alternate
    req(0, 32'h1000, 8'd1); req(1, 32'h2000, 8'd2);
    expect_txn(0, 32'h1000, 8'd1, 2); expect_txn(1, 32'h2000, 8'd2, 3);
    run(200);
    req(0, 32'h3000, 8'd0); req(0, 32'h3100, 8'd0); req(1, 32'h4000, 8'd1); req(1, 32'h4100, 8'd0);
    expect_txn(0, 32'h3000, 8'd0, 1); expect_txn(1, 32'h4000, 8'd1, 2);
    expect_txn(0, 32'h3100, 8'd0, 1); expect_txn(1, 32'h4100, 8'd0, 1);
    run(200);
    req(1, 32'h5000, 8'd0);
    expect_txn(1, 32'h5000, 8'd0, 1);
    run(100);
    chk("rr_err", err, 0);
    // Fixed priority: M0 back-to-back starves M1 until M0 stops requesting
    do_reset(1'b1);
    chk_reset_outs();
    req(0, 32'h0100, 8'd0); req(0, 32'h0200, 8'd1); req(0, 32'h0300, 8'd0); req(1, 32'h0900, 8'd0);
    expect_txn(0, 32'h0100, 8'd0, 1); expect_txn(0, 32'h0200, 8'd1, 2);
    expect_txn(0, 32'h0300, 8'd0, 1); expect_txn(1, 32'h0900, 8'd0, 1);
    run(200);
    chk("fp_err", err, 0);
    // Backpressure: delayed ARREADY, toggling master RREADY
    do_reset(1'b0);
    ar_delay = 5; tog = 1'b1;
    req(1, 32'h8000, 8'd7);
    expect_txn(1, 32'h8000, 8'd7, 8);
    run(300);
    chk("bp_err", err, 0);
    // Reset mid-burst after first beat, then a fresh M1 request with one-cycle ARVALID latency
    do_reset(1'b0);
    req(0, 32'hA000, 8'd3);
    expect_txn(0, 32'hA000, 8'd3, 4);
    s = beats_seen;
    run_beats(s + 1);
    rst = 1'b1;
    m_arvalid = 2'b00;
    exp_ar.delete(); exp_r.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outs();
    expect_txn(1, 32'hB000, 8'd2, 3);
    load(1, '{32'hB000, 8'd2});
    @(negedge clk);
    chk("lat_before", s_arvalid, 0);
    @(posedge clk);
    #1 chk("lat_after", s_arvalid, 1);
    run(100);
    chk("post_rst_err", err, 0);
    // Length errors: early RLAST, then sticky flag survives a clean burst
    do_reset(1'b0);
    rlast_at = 2;
    req(0, 32'hC000, 8'd2);
    expect_txn(0, 32'hC000, 8'd2, 2);
    run(100);
    chk("early_rlast_err", err, 1);
    rlast_at = 0;
    req(1, 32'hD000, 8'd1);
    expect_txn(1, 32'hD000, 8'd1, 2);
    run(100);
    chk("err_sticky", err, 1);
    // Late RLAST: flag rises on the third beat, not before
    do_reset(1'b0);
    chk("err_cleared", err, 0);
    rlast_at = 4;
    req(0, 32'hE000, 8'd2);
    expect_txn(0, 32'hE000, 8'd2, 4);
    s = beats_seen;
    run_beats(s + 2);
    chk("late_err_beat2", err, 0);
    run_beats(s + 3);
    chk("late_err_beat3", err, 1);
    run(100);
    chk("late_err_end", err, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi4_rd_arbiter.md
AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with M0 highest.
REQ-002 SHALL have port ACLK, input, 1 bit: sole clock; all logic on its rising edge.
REQ-003 SHALL have port ARESET, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port M_ARADDR, input, 64 bits: {M1, M0} read addresses, 32 bits each.
REQ-005 SHALL have port M_ARLEN, input, 16 bits: {M1, M0} burst lengths, 8 bits each.
REQ-006 SHALL have port M_ARSIZE, input, 6 bits: {M1, M0}, 3 bits each.
REQ-007 SHALL have port M_ARBURST, input, 4 bits: {M1, M0}, 2 bits each.
REQ-008 SHALL have port M_ARVALID, input, 2 bits: per-master address valid.
REQ-009 SHALL have port M_ARREADY, output, 2 bits: per-master address ready.
REQ-010 SHALL have port M_RDATA, output, 32 bits: read data, broadcast to both masters.
REQ-011 SHALL have port M_RRESP, output, 2 bits: read response, broadcast.
REQ-012 SHALL have port M_RLAST, output, 1 bit: last beat, broadcast.
REQ-013 SHALL have port M_RVALID, output, 2 bits: per-master read valid.
REQ-014 SHALL have port M_RREADY, input, 2 bits: per-master read ready.
REQ-015 SHALL have ports S_AXI_ARID (1), S_AXI_ARADDR (32), S_AXI_ARLEN (8), S_AXI_ARSIZE (3), S_AXI_ARBURST (2), S_AXI_ARVALID (1), S_AXI_RREADY (1) as outputs to the shared slave.
REQ-016 SHALL have ports S_AXI_ARREADY (1), S_AXI_RID (1), S_AXI_RDATA (32), S_AXI_RRESP (2), S_AXI_RLAST (1), S_AXI_RVALID (1) as inputs from the shared slave.
REQ-017 SHALL have port ERR_LEN, output, 1 bit: sticky burst-length error flag.

Function
REQ-018 SHALL allow one outstanding read transaction at a time, using FSM states IDLE, ADDR and DATA.
REQ-019 In IDLE with any M_ARVALID high, SHALL select grant g, register g's address fields and S_AXI_ARID=g, and enter ADDR; S_AXI_ARVALID SHALL rise on the next cycle.
REQ-020 Arbitration with RR_EN=1 SHALL favour the master not granted last when both request; a single requester SHALL always win.
REQ-021 Arbitration with RR_EN=0 SHALL pick M0 whenever M_ARVALID[0]=1.
REQ-022 ADDR SHALL hold S_AXI_ARVALID and the address fields stable until S_AXI_ARREADY=1.
REQ-023 M_ARREADY[g] SHALL equal S_AXI_ARREADY while in ADDR, and SHALL be 0 otherwise and for the non-granted master.
REQ-024 On the ADDR handshake, SHALL drop S_AXI_ARVALID next cycle, enter DATA, and clear the beat counter to 0.
REQ-025 DATA routing, combinational:
- M_RVALID[g] = S_AXI_RVALID; M_RVALID[!g] = 0.
- S_AXI_RREADY = M_RREADY[g].
- M_RDATA, M_RRESP and M_RLAST pass through unchanged.
REQ-026 Each beat (S_AXI_RVALID & S_AXI_RREADY) SHALL increment the 8-bit beat counter; S_AXI_RID SHALL be ignored for routing.
REQ-027 On a beat with S_AXI_RLAST=1, SHALL return to IDLE next cycle and record g as last granted; a new grant is possible in that IDLE cycle.
REQ-028 SHALL set ERR_LEN on either burst-length mismatch, with the FSM otherwise unaffected and ERR_LEN cleared only by reset:
- RLAST beat with counter != captured ARLEN.
- Non-RLAST beat with counter == captured ARLEN.
REQ-029 ARVALID deasserting in IDLE before grant SHALL cause no grant; requests arriving while ADDR/DATA are active SHALL wait with M_ARREADY=0.
REQ-030 An idle-to-idle request-to-S_AXI_ARVALID latency of exactly 1 cycle SHALL hold.

Reset
REQ-031 ARESET=1 at any time, including mid-burst, SHALL on the next edge force:
- State: IDLE.
- Slave outputs: S_AXI_ARVALID=0, S_AXI_RREADY=0, all S_AXI_AR* fields 0.
- Master outputs: M_ARREADY=0, M_RVALID=0.
- Flags and counters: ERR_LEN=0, beat counter 0.
- Last granted = M1, so M0 wins the first contest.

Verification
REQ-032 Reset mid-burst: M0 burst ARLEN=3 reset after beat 1 -> all outputs at reset values next cycle; a fresh M1 request then completes normally.
REQ-033 Simultaneous requests, RR_EN=1: both ARVALID, M0 ARADDR=0x1000, M1 ARADDR=0x2000 -> order M0 then M1; S_AXI_ARID 0 then 1; M_RVALID[1] never high during M0 data.
REQ-034 Fixed priority, RR_EN=0: M0 issues back-to-back requests while M1 requests continuously -> M1 starved until M0 ARVALID drops.
REQ-035 Backpressure: M1 ARLEN=7, slave ARREADY delayed 5 cycles, M_RREADY[1] toggling -> address stable throughout; 8 beats delivered; S_AXI_RREADY mirrors M_RREADY[1].
REQ-036 Length errors: ARLEN=2 with RLAST on beat 2 -> ERR_LEN=1 and IDLE reached; separately RLAST on beat 4 -> ERR_LEN=1 after beat 3.
